// File: rtl/mul_seq_ctrl_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mul_seq_ctrl_pkg;

  localparam int unsigned W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_ctrl_add_w.sv
// W-bit unsigned adder with carry-out; the multiplier's only datapath arithmetic.
module add_w #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add unsigned multiplier with valid/ready handshakes on both sides.
// One partial-product step per CALC cycle; always exactly W steps per operation.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int unsigned CW = $clog2(W + 1);

  state_t          state, state_nxt;
  logic [W-1:0]    mcand, mcand_nxt;
  logic [W-1:0]    mq, mq_nxt;
  logic [W-1:0]    acc_hi, acc_hi_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic [W-1:0]    addend;
  logic [W-1:0]    sum;
  logic            carry;

  assign addend = mq[0] ? mcand : '0;

  add_w #(.W(W)) u_add (
    .x  (acc_hi),
    .y  (addend),
    .s  (sum),
    .co (carry)
  );

  // Status outputs are pure decodes of the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign p         = {acc_hi, mq};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mq     <= '0;
      acc_hi <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      mcand  <= mcand_nxt;
      mq     <= mq_nxt;
      acc_hi <= acc_hi_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mq_nxt     = mq;
    acc_hi_nxt = acc_hi;
    cnt_nxt    = cnt;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          mcand_nxt  = a;
          mq_nxt     = b;
          acc_hi_nxt = '0;
          cnt_nxt    = '0;
          state_nxt  = CALC;
        end
      end
      CALC: begin
        // Carry and sum shift down into the high half as the multiplier bit retires.
        {acc_hi_nxt, mq_nxt} = {carry, sum, mq[W-1:1]};
        cnt_nxt              = cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed and exhaustive checks of the sequential multiplier at W=4.
module tb_mul_seq_ctrl;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (p !== 8'h00) begin errors++; $display("FAIL reset_p: got %h want 00", p); end
    // First cycle out of reset must already accept an operand pair.
    rst_n = 1'b1; in_valid = 1'b1; a = 4'd2; b = 4'd3; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_transfer_busy: got %b want 1", busy); end
    repeat (W) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_op_valid: got %b want 1", out_valid); end
    checks++; if (p !== 8'h06) begin errors++; $display("FAIL first_op_p: got %h want 06", p); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_op_idle: got %b want 1", in_ready); end
  endtask

  task automatic test_max_product();
    in_valid = 1'b1; a = 4'd15; b = 4'd15; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < int'(W); j++) begin
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL max_calc_%0d: got valid=%b busy=%b ready=%b want 0 1 0", j, out_valid, busy, in_ready);
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL max_valid: got %b want 1", out_valid); end
    checks++; if (p !== 8'hE1) begin errors++; $display("FAIL max_p: got %h want e1", p); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL max_return: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_zero_operands();
    logic [W-1:0] av [2];
    logic [W-1:0] bv [2];
    av[0] = 4'd0; bv[0] = 4'd9;
    av[1] = 4'd9; bv[1] = 4'd0;
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      in_valid = 1'b1; a = av[t]; b = bv[t];
      @(negedge clk);
      in_valid = 1'b0;
      for (int j = 0; j < int'(W); j++) begin
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          errors++; $display("FAIL zero_%0d_calc_%0d: got busy=%b valid=%b want 1 0", t, j, busy, out_valid);
        end
        @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1 || p !== 8'h00) begin
        errors++; $display("FAIL zero_%0d_result: got valid=%b p=%h want 1 00", t, out_valid, p);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_output_stall();
    in_valid = 1'b1; a = 4'd13; b = 4'd11; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || p !== 8'h8F) begin
        errors++; $display("FAIL stall_%0d: got valid=%b p=%h want 1 8f", i, out_valid, p);
      end
      if (i == 4) out_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_inputs();
    in_valid = 1'b1; a = 4'd3; b = 4'd5; out_ready = 1'b1;
    @(negedge clk);
    // Hostile inputs throughout CALC, including out_ready toggling.
    for (int j = 0; j < int'(W); j++) begin
      in_valid = 1'b1;
      a = (j % 2 == 0) ? 4'd7 : 4'd12;
      b = (j % 2 == 0) ? 4'd7 : 4'd1;
      out_ready = (j % 2 == 0);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL ignore_ready_%0d: got %b want 0", j, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || p !== 8'h0F) begin
      errors++; $display("FAIL ignore_result: got valid=%b p=%h want 1 0f", out_valid, p);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ignore_return: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_abort();
    int seen;
    in_valid = 1'b1; a = 4'd5; b = 4'd5; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || p !== 8'h00) begin
      errors++; $display("FAIL abort_state: got ready=%b busy=%b p=%h want 1 0 00", in_ready, busy, p);
    end
    seen = 0;
    repeat (W + 3) begin
      if (out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen); end
    in_valid = 1'b1; a = 4'd6; b = 4'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || p !== 8'h2A) begin
      errors++; $display("FAIL abort_next_op: got valid=%b p=%h want 1 2a", out_valid, p);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_p;
    int sent, recv, cycles;
    sent = 0; recv = 0; cycles = 0;
    while (recv < 256 && cycles < 20000) begin
      in_valid  = (sent < 256);
      a         = W'(sent / 16);
      b         = W'(sent % 16);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(8'(a) * 8'(b));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious: got p=%h want no result", p);
        end else begin
          exp_p = exp_q.pop_front();
          if (p !== exp_p) begin
            errors++; $display("FAIL b2b_p_%0d: got %h want %h", recv, p, exp_p);
          end
        end
        recv++;
      end
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv !== 256 || sent !== 256) begin
      errors++; $display("FAIL b2b_count: got sent=%0d recv=%0d want 256 256", sent, recv);
    end
  endtask

  initial begin
    test_reset();
    test_max_product();
    test_zero_operands();
    test_output_stall();
    test_ignore_inputs();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
